// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM states, PCSrc encodings, NOP word
// and the j/jal target helper.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10
    } fetchState_e;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // j/jal keep the top nibble of the delay-slot PC and splice in the word index.
    function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4,
                                               input logic [25:0] jumpIndex);
        return {pcPlus4[31:28], jumpIndex, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// next_pc_calc: combinational next-PC selection (sequential, branch, jump, register jump).
// Alignment handling is left to the caller.
module next_pc_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pcPlus4,
    input  logic [25:0] jumpIndex,
    input  logic [1:0]  pcSrc,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branchImm,
    input  logic [31:0] rsData,
    output logic [31:0] nextPc
);

    always_comb begin
        nextPc = pcPlus4;
        case (pcSrc)
            PC_SEQ: nextPc = pcPlus4;
            PC_BR: begin
                if (branch && zero) begin
                    nextPc = pcPlus4 + (branchImm << 2);
                end
            end
            PC_J:    nextPc = jumpTarget(pcPlus4, jumpIndex);
            PC_JR:   nextPc = rsData;
            default: nextPc = pcPlus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word over req/ack, holds it until commit.
// Define ALIGN_CHECK_EN to redirect misaligned next-PCs to EXC_VECTOR and raise fetch_exc.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  PCSrc,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] BranchImm,
    input  logic [31:0] RsData,
    input  logic        commit,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] PC_plus_4,
    output logic        instr_valid,
    output logic        fetch_exc
);

    fetchState_e stateReg, stateNext;
    logic [31:0] pcReg, pcNext;
    logic [31:0] instrReg, instrNext;
    logic        validReg, validNext;
    logic [31:0] pcPlus4;
    logic [31:0] rawNextPc;

    assign pcPlus4 = pcReg + 32'd4;

    next_pc_calc uNextPc (
        .pcPlus4   (pcPlus4),
        .jumpIndex (instrReg[25:0]),
        .pcSrc     (PCSrc),
        .branch    (Branch),
        .zero      (Zero),
        .branchImm (BranchImm),
        .rsData    (RsData),
        .nextPc    (rawNextPc)
    );

`ifdef ALIGN_CHECK_EN
    logic excReg, excNext;
    assign fetch_exc = excReg;
`else
    logic unusedExcVector;
    assign unusedExcVector = ^EXC_VECTOR;
    assign fetch_exc       = 1'b0;
`endif

    always_comb begin
        stateNext = stateReg;
        pcNext    = pcReg;
        instrNext = instrReg;
        validNext = validReg;
`ifdef ALIGN_CHECK_EN
        excNext   = excReg;
`endif
        case (stateReg)
            ST_IDLE: stateNext = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instrNext = imem_rdata;
                    validNext = 1'b1;
                    stateNext = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (commit) begin
                    validNext = 1'b0;
                    stateNext = ST_FETCH;
`ifdef ALIGN_CHECK_EN
                    if (rawNextPc[1:0] != 2'b00) begin
                        pcNext  = EXC_VECTOR;
                        excNext = 1'b1;
                    end else begin
                        pcNext  = rawNextPc;
                        excNext = 1'b0;
                    end
`else
                    pcNext = rawNextPc & 32'hFFFF_FFFC;
`endif
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg <= ST_IDLE;
            pcReg    <= RESET_PC;
            instrReg <= NOP_WORD;
            validReg <= 1'b0;
`ifdef ALIGN_CHECK_EN
            excReg   <= 1'b0;
`endif
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            instrReg <= instrNext;
            validReg <= validNext;
`ifdef ALIGN_CHECK_EN
            excReg   <= excNext;
`endif
        end
    end

    assign imem_req    = (stateReg == ST_FETCH);
    assign imem_addr   = pcReg;
    assign PC          = pcReg;
    assign PC_plus_4   = pcPlus4;
    assign Instruction = instrReg;
    assign instr_valid = validReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded random bench for instr_fetch_unit: a driver issues fetch/commit traffic
// and pushes expectations; a monitor pops and compares whenever the DUT presents a fetch or an instruction.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
    localparam int          NUM_DIR    = 13;
    localparam int          NUM_TX     = 60;

    typedef struct {
        logic [1:0]  src;
        logic        br;
        logic        z;
        logic [31:0] imm;
        logic [31:0] rs;
        logic [31:0] word;
        int          delay;
    } tx_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } execExp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  PCSrc;
    logic        Branch;
    logic        Zero;
    logic [31:0] BranchImm;
    logic [31:0] RsData;
    logic        commit;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] PC_plus_4;
    logic        instr_valid;
    logic        fetch_exc;

    int assertions = 0;
    int failures   = 0;
    bit monEn      = 1'b1;

    logic [31:0] addrQ[$];
    execExp_t    execQ[$];
    tx_t         dir[NUM_DIR];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PCSrc       (PCSrc),
        .Branch      (Branch),
        .Zero        (Zero),
        .BranchImm   (BranchImm),
        .RsData      (RsData),
        .commit      (commit),
        .Instruction (Instruction),
        .PC          (PC),
        .PC_plus_4   (PC_plus_4),
        .instr_valid (instr_valid),
        .fetch_exc   (fetch_exc)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tx_t mk(input logic [1:0] src, input logic br, input logic z,
                               input logic [31:0] imm, input logic [31:0] rs,
                               input logic [31:0] word, input int delay);
        tx_t t;
        t.src = src; t.br = br; t.z = z; t.imm = imm; t.rs = rs; t.word = word; t.delay = delay;
        return t;
    endfunction

    // Reference next-PC, straight from the PCSrc rules using plain arithmetic.
    function automatic logic [31:0] modelTarget(input tx_t t, input logic [31:0] pc);
        logic [31:0] seq;
        seq = pc + 32'd4;
        case (t.src)
            2'd0:    return seq;
            2'd1:    return (t.br && t.z) ? seq + t.imm * 32'd4 : seq;
            2'd2:    return (seq & 32'hF000_0000) + (t.word & 32'h03FF_FFFF) * 32'd4;
            default: return t.rs;
        endcase
    endfunction

    // Monitor: compares every fetch request and every presented instruction against the scoreboard.
    initial begin
        logic [31:0] curAddr;
        execExp_t    cur;
        logic        prevReq;
        logic        prevValid;
        curAddr = '0; cur.pc = '0; cur.instr = '0; cur.exc = 1'b0;
        prevReq = 1'b0; prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (monEn && reset === 1'b1) begin
                if (imem_req === 1'b1) begin
                    if (prevReq !== 1'b1) begin
                        if (addrQ.size() == 0) begin
                            checkVal("fetch_unexpected", imem_addr, 32'hxxxx_xxxx);
                        end else begin
                            curAddr = addrQ.pop_front();
                            checkVal("fetch_addr", imem_addr, curAddr);
                        end
                    end else begin
                        checkVal("fetch_addr_stable", imem_addr, curAddr);
                    end
                    checkBit("valid_low_in_fetch", instr_valid, 1'b0);
                end
                if (instr_valid === 1'b1) begin
                    if (prevValid !== 1'b1) begin
                        if (execQ.size() == 0) begin
                            checkVal("exec_unexpected", PC, 32'hxxxx_xxxx);
                        end else begin
                            cur = execQ.pop_front();
                            $display("exec pc=%h instr=%h pc4=%h exc=%b", PC, Instruction, PC_plus_4, fetch_exc);
                            checkVal("exec_pc", PC, cur.pc);
                            checkVal("exec_instr", Instruction, cur.instr);
                            checkVal("exec_pc_plus_4", PC_plus_4, cur.pc + 32'd4);
                            checkBit("exec_fetch_exc", fetch_exc, cur.exc);
                        end
                    end else begin
                        checkVal("exec_instr_held", Instruction, cur.instr);
                        checkVal("exec_pc_held", PC, cur.pc);
                    end
                    checkBit("req_low_in_exec", imem_req, 1'b0);
                end
            end
            prevReq   = imem_req;
            prevValid = instr_valid;
        end
    end

    // Driver / reference model.
    initial begin
        logic [31:0] mPc;
        logic        mExc;
        logic [31:0] target;
        logic [15:0] r16;
        tx_t         t;
        int          n;
        bit          aborted;

        dir[0]  = mk(2'd3, 1'b0, 1'b0, 32'h0,         32'h0000_0040, 32'h2008_0005, 1);
        dir[1]  = mk(2'd0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0123_4567, 0);
        dir[2]  = mk(2'd3, 1'b0, 1'b0, 32'h0,         32'h0000_0100, 32'h1111_0000, 2);
        dir[3]  = mk(2'd1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0,         32'h1000_FFFE, 5);
        dir[4]  = mk(2'd3, 1'b0, 1'b0, 32'h0,         32'h0000_0100, 32'h2222_0000, 0);
        dir[5]  = mk(2'd1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'h1000_FFFE, 1);
        dir[6]  = mk(2'd3, 1'b0, 1'b0, 32'h0,         32'h1000_0000, 32'h3333_0000, 0);
        dir[7]  = mk(2'd2, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0800_0010, 3);
        dir[8]  = mk(2'd3, 1'b0, 1'b0, 32'h0,         32'h0040_0020, 32'h4444_0000, 0);
        dir[9]  = mk(2'd3, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h5555_0000, 1);
        dir[10] = mk(2'd0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h6666_0000, 0);
        dir[11] = mk(2'd3, 1'b0, 1'b0, 32'h0,         32'h0000_0102, 32'h7777_0000, 2);
        dir[12] = mk(2'd3, 1'b0, 1'b0, 32'h0,         32'h0000_0100, 32'h8888_0000, 0);

        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; PCSrc = '0; Branch = 1'b0;
        Zero = 1'b0; BranchImm = '0; RsData = '0; commit = 1'b0;
        aborted = 1'b0;
        mPc = RESET_PC; mExc = 1'b0;
        addrQ.push_back(RESET_PC);

        repeat (2) @(negedge clk);
        $display("reset pc=%h req=%b valid=%b", PC, imem_req, instr_valid);
        checkBit("reset_req", imem_req, 1'b0);
        checkBit("reset_valid", instr_valid, 1'b0);
        checkVal("reset_pc", PC, RESET_PC);
        checkVal("reset_instr", Instruction, 32'h0);
        checkBit("reset_exc", fetch_exc, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < NUM_TX && !aborted; i++) begin
            if (i < NUM_DIR) begin
                t = dir[i];
            end else begin
                r16 = 16'($urandom);
                t.src   = 2'($urandom_range(0, 3));
                t.br    = 1'($urandom);
                t.z     = 1'($urandom);
                t.imm   = {{16{r16[15]}}, r16};
                t.rs    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
                t.word  = $urandom;
                t.delay = $urandom_range(0, 5);
            end

            n = 0;
            while (imem_req !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (imem_req !== 1'b1) begin
                checkBit("fetch_req_timeout", imem_req, 1'b1);
                aborted = 1'b1;
                break;
            end

            // Stall the ack; stray commits here must be ignored.
            for (int d = 0; d < t.delay; d++) begin
                imem_ack = 1'b0;
                commit   = 1'($urandom);
                PCSrc    = 2'($urandom);
                RsData   = $urandom;
                @(negedge clk);
            end
            commit     = 1'b0;
            imem_ack   = 1'b1;
            imem_rdata = t.word;
            execQ.push_back('{pc: mPc, instr: t.word, exc: mExc});
            @(negedge clk);

            // Spurious acks during EXEC must not disturb the held instruction.
            n = $urandom_range(0, 3);
            for (int w = 0; w < n; w++) begin
                imem_ack   = 1'($urandom);
                imem_rdata = $urandom;
                PCSrc      = 2'($urandom);
                @(negedge clk);
            end

            imem_ack  = 1'b0;
            PCSrc     = t.src;
            Branch    = t.br;
            Zero      = t.z;
            BranchImm = t.imm;
            RsData    = t.rs;
            commit    = 1'b1;
            target    = modelTarget(t, mPc);
`ifdef ALIGN_CHECK_EN
            if (target % 4 != 0) begin
                mPc = EXC_VECTOR; mExc = 1'b1;
            end else begin
                mPc = target; mExc = 1'b0;
            end
`else
            mPc = target - (target % 4);
`endif
            addrQ.push_back(mPc);
            @(negedge clk);
            commit = 1'b0;
        end

        if (!aborted) begin
            // Reset while a fetch is outstanding, then a late ack landing in IDLE.
            checkBit("pre_reset_in_fetch", imem_req, 1'b1);
            monEn = 1'b0;
            reset = 1'b0;
            @(negedge clk);
            $display("midfetch reset pc=%h req=%b", PC, imem_req);
            checkVal("midfetch_reset_pc", PC, RESET_PC);
            checkBit("midfetch_reset_req", imem_req, 1'b0);
            checkBit("midfetch_reset_valid", instr_valid, 1'b0);
            checkBit("midfetch_reset_exc", fetch_exc, 1'b0);
            reset      = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            imem_ack = 1'b0;
            $display("late ack dropped req=%b addr=%h valid=%b", imem_req, imem_addr, instr_valid);
            checkBit("late_ack_req", imem_req, 1'b1);
            checkVal("late_ack_addr", imem_addr, RESET_PC);
            checkBit("late_ack_valid", instr_valid, 1'b0);
            checkVal("late_ack_instr", Instruction, 32'h0);
            checkVal("scoreboard_exec_drained", 32'(execQ.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the MIPS core. Sits directly upstream of the main decoder.
- Owns the PC register and fetches one instruction word through a req/ack instruction-memory port.
- Presents the held instruction, PC and PC+4 to decode/execute. Waits for the datapath to commit.
- Computes the next PC from the decoder's PCSrc/Branch outputs and the ALU Zero flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, redirect target on a misaligned fetch (used only with ALIGN_CHECK_EN).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous reset, active-low (reset==0 resets).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch byte address.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched word.
- PCSrc  in  2  from decoder: 00 seq, 01 branch, 10 j/jal, 11 jr/jalr.
- Branch  in  1  from decoder.
- Zero  in  1  ALU zero flag.
- BranchImm  in  32  sign-extended 16-bit immediate.
- RsData  in  32  register rs value (jr/jalr target).
- commit  in  1  datapath finished the current instruction.
- Instruction  out  32  held instruction word.
- PC  out  32  address of the held instruction.
- PC_plus_4  out  32  PC+4, used for jal/jalr link.
- instr_valid  out  1  Instruction/PC are valid for execute.
- fetch_exc  out  1  misaligned-fetch flag (0 when ALIGN_CHECK_EN is not defined).

Behaviour:
- Three states: IDLE, FETCH, EXEC. Registered state and outputs.
- Reset (edge with reset==0):
  - state=IDLE, PC=RESET_PC, Instruction=32'h0, instr_valid=0, fetch_exc=0.
  - imem_req is 0 in IDLE.
- IDLE: imem_req=0. Next cycle go to FETCH unconditionally. Any imem_ack seen here is ignored.
- FETCH:
  - imem_req=1 and imem_addr=PC, both held stable until ack.
  - On an edge with imem_ack=1: Instruction<=imem_rdata, instr_valid<=1, go to EXEC.
  - Minimum latency is 1 cycle (ack in the first FETCH cycle).
- EXEC:
  - imem_req=0. Instruction, PC and instr_valid are held.
  - On an edge with commit=1: PC<=next_pc, instr_valid<=0, Instruction held, go to FETCH.
  - commit outside EXEC is ignored. imem_ack outside FETCH is ignored.
- imem_addr equals PC in all states; it is only meaningful while imem_req=1.
- PC_plus_4 = PC+32'd4, combinational from the PC register, modulo 2^32.
- next_pc:
  - 00: PC+4.
  - 01: if Branch&Zero, PC+4+(BranchImm<<2); otherwise PC+4.
  - 10: {PC_plus_4[31:28], Instruction[25:0], 2'b00}.
  - 11: RsData.
- All next_pc adds are 32-bit and wrap silently (e.g. 32'hFFFF_FFFC+4 = 0).
- Back-to-back operation: commit and the next FETCH entry give one instruction per 2+ cycles. No prefetch.
- Reset mid-FETCH: request is abandoned. The memory must not ack while imem_req=0; a late ack landing in IDLE is dropped.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- When defined:
  - On commit, if next_pc[1:0]!=2'b00: PC<=EXC_VECTOR, fetch_exc<=1.
  - fetch_exc is cleared on the next commit with an aligned next_pc, or on reset.
- When not defined:
  - next_pc[1:0] are forced to 00 before loading PC.
  - fetch_exc is tied to 0.

Decomposition:
- Shared package holds:
  - PCSrc encodings: PC_SEQ=2'b00, PC_BR=2'b01, PC_J=2'b10, PC_JR=2'b11.
  - State encoding constants.
  - NOP word 32'h0.
- One natural sub-module: next_pc_calc (combinational next-PC mux/adders). The FSM and registers stay in the top.

Test Plan:
- Reset and first fetch: hold reset=0 for 2 cycles, then release → imem_req rises one cycle after IDLE with imem_addr=0; ack with 32'h2008_0005 on the 2nd FETCH cycle → Instruction=32'h2008_0005, instr_valid=1.
- Sequential: PC=0x40, PCSrc=00, commit → next imem_addr=0x44. PC_plus_4 is 0x44 while PC=0x40.
- Branch:
  - PC=0x100, PCSrc=01, Branch=1, Zero=1, BranchImm=32'hFFFF_FFFE → next PC=0xFC.
  - Same stimulus with Zero=0 → next PC=0x104.
- Jump and register jump:
  - PC=0x1000_0000, PCSrc=10, Instruction[25:0]=26'h000_0010 → next PC=0x1000_0040.
  - PCSrc=11, RsData=0x0040_0020 → next PC=0x0040_0020.
- Handshake and ignore rules:
  - Delay ack by 5 cycles → imem_addr stable and instr_valid=0 throughout.
  - commit pulsed during FETCH → no PC change.
  - Reset asserted mid-FETCH → PC=RESET_PC, imem_req=0 next cycle.
- Wrap and alignment:
  - PC=32'hFFFF_FFFC, seq commit → next PC=0.
  - With ALIGN_CHECK_EN, PCSrc=11, RsData=0x0000_0102 → PC=EXC_VECTOR, fetch_exc=1.
  - Without ALIGN_CHECK_EN, same stimulus → PC=0x0000_0100.
